// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone peripheral port among N controllers.
// Registered grant, combinational ack/data return, per-transaction watchdog.
module wb_arbiter #(
   parameter int N       = 2,
   parameter int ADR_W   = 4,
   parameter int DAT_W   = 8,
   parameter int TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       c_stb,
   input  logic [N-1:0]       c_we,
   input  logic [N*ADR_W-1:0] c_adr,
   input  logic [N*DAT_W-1:0] c_dat,
   output logic [N-1:0]       c_ack,
   output logic [N-1:0]       c_err,
   output logic [DAT_W-1:0]   c_rdat,
   output logic               p_stb,
   output logic               p_we,
   output logic [ADR_W-1:0]   p_adr,
   output logic [DAT_W-1:0]   p_dat,
   input  logic               p_ack,
   input  logic [DAT_W-1:0]   p_rdat,
   output logic [N-1:0]       grant,
   output logic               busy
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t         state;
   logic [IW-1:0]  own;
   logic [IW-1:0]  last;
   logic [TW-1:0]  timer;
   logic [IW-1:0]  pick;
   logic           found;
   int             j;
   logic           strobe;
   logic           at_to;
   logic           ack_ok;
   logic           done;

   // first requester after the previous owner, wrapping mod N
   always_comb begin
      pick  = last;
      found = 1'b0;
      j     = 0;
      for (int k = 1; k <= N; k++) begin
         j = (int'(last) + k) % N;
         if (!found && c_stb[j]) begin
            pick  = IW'(j);
            found = 1'b1;
         end
      end
   end

   assign busy   = (state == BUSY);
   assign strobe = busy & c_stb[own];
   assign at_to  = (TIMEOUT > 0) && strobe && (timer == TW'(TIMEOUT));
   assign ack_ok = strobe & p_ack;
   assign done   = ack_ok | at_to;

   assign p_stb  = strobe & ~at_to;
   assign p_we   = busy & c_we[own];
   assign p_adr  = busy ? c_adr[int'(own)*ADR_W +: ADR_W] : '0;
   assign p_dat  = busy ? c_dat[int'(own)*DAT_W +: DAT_W] : '0;
   assign c_ack  = grant & {N{done}};
   assign c_err  = grant & {N{at_to & ~ack_ok}};
   assign c_rdat = ack_ok ? p_rdat : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         grant <= '0;
         own   <= '0;
         last  <= IW'(N - 1);
         timer <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (|c_stb) begin
                  state <= BUSY;
                  grant <= N'(1) << pick;
                  own   <= pick;
                  last  <= pick;
                  timer <= '0;
               end
            end
            BUSY: begin
               if (done || !c_stb[own]) begin
                  state <= IDLE;
                  grant <= '0;
               end else if (TIMEOUT > 0 && timer != TW'(TIMEOUT)) begin
                  timer <= timer + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized
// traffic against a cycle-level behavioural reference model.
module tb_wb_arbiter;

   localparam int N  = 3;
   localparam int AW = 4;
   localparam int DW = 8;
   localparam int TO = 15;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    c_stb, c_we;
   logic [N*AW-1:0] c_adr;
   logic [N*DW-1:0] c_dat;
   logic [N-1:0]    c_ack, c_err;
   logic [DW-1:0]   c_rdat;
   logic            p_stb, p_we;
   logic [AW-1:0]   p_adr;
   logic [DW-1:0]   p_dat;
   logic            p_ack;
   logic [DW-1:0]   p_rdat;
   logic [N-1:0]    grant;
   logic            busy;
   logic            ack_en;

   wb_arbiter #(.N(N), .ADR_W(AW), .DAT_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .c_stb(c_stb), .c_we(c_we), .c_adr(c_adr), .c_dat(c_dat),
      .c_ack(c_ack), .c_err(c_err), .c_rdat(c_rdat),
      .p_stb(p_stb), .p_we(p_we), .p_adr(p_adr), .p_dat(p_dat),
      .p_ack(p_ack), .p_rdat(p_rdat),
      .grant(grant), .busy(busy)
   );

   always #5 clk = ~clk;

   // combinational peripheral: acks in the strobe cycle when enabled
   assign p_ack = p_stb & ack_en;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: owner (-1 = idle), last owner, busy-cycle counter
   int mown, mlast, mtim;
   logic [N-1:0]  e_grant, e_ack, e_err;
   logic          e_busy, e_pstb, e_we, e_leave;
   logic [AW-1:0] e_adr;
   logic [DW-1:0] e_dat, e_rdat;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mown  = -1;
      mlast = N - 1;
      mtim  = 0;
   endtask

   task automatic eval();
      int  g;
      bit  s, tmo, pa;
      e_grant = '0; e_ack = '0; e_err = '0; e_rdat = '0;
      e_busy = 0; e_pstb = 0; e_we = 0; e_adr = '0; e_dat = '0;
      e_leave = 0;
      if (mown >= 0) begin
         g = mown;
         s = c_stb[g];
         tmo = s && (mtim == TO);
         pa = s && !tmo && ack_en;
         e_busy = 1;
         e_grant[g] = 1'b1;
         e_pstb = s && !tmo;
         e_we = c_we[g];
         e_adr = c_adr[g*AW +: AW];
         e_dat = c_dat[g*DW +: DW];
         if (pa) begin
            e_ack[g] = 1'b1;
            e_rdat = p_rdat;
         end else if (tmo) begin
            e_ack[g] = 1'b1;
            e_err[g] = 1'b1;
         end
         e_leave = !s || pa || tmo;
      end
   endtask

   task automatic model_step();
      bit hit;
      if (mown < 0) begin
         hit = 0;
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (mlast + k) % N;
            if (!hit && c_stb[c]) begin
               hit = 1;
               mown = c;
               mlast = c;
               mtim = 0;
            end
         end
      end else if (e_leave) begin
         mown = -1;
      end else if (mtim < TO) begin
         mtim++;
      end
   endtask

   // entered in the low phase with inputs settled; returns at next negedge
   task automatic tick();
      #1;
      eval();
      chk("grant", 32'(grant), 32'(e_grant));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("p_stb", 32'(p_stb), 32'(e_pstb));
      chk("c_ack", 32'(c_ack), 32'(e_ack));
      chk("c_err", 32'(c_err), 32'(e_err));
      chk("c_rdat", 32'(c_rdat), 32'(e_rdat));
      if (e_pstb) begin
         chk("p_we", 32'(p_we), 32'(e_we));
         chk("p_adr", 32'(p_adr), 32'(e_adr));
         chk("p_dat", 32'(p_dat), 32'(e_dat));
      end
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      c_stb = '0;
      #2;
      chk("rst_grant", 32'(grant), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_pstb", 32'(p_stb), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic [N-1:0] prev_grant;
      int  wait_cnt [N];
      bit  noack;

      rst = 1'b0; c_stb = '0; c_we = '0; c_adr = '0; c_dat = '0;
      p_rdat = '0; ack_en = 1'b0;
      model_reset();
      @(negedge clk);
      #1;
      chk("rst_cack", 32'(c_ack), 0);
      chk("rst_cerr", 32'(c_err), 0);
      chk("rst_rdat", 32'(c_rdat), 0);
      @(negedge clk);
      rst = 1'b1;

      // single write from c0
      c_stb = 3'b001; c_we = 3'b001;
      c_adr[0 +: AW] = 4'd3; c_dat[0 +: DW] = 8'hA5; ack_en = 1'b1;
      #1 chk("wr_idle_ack", 32'(c_ack), 0);
      tick();
      #1;
      chk("wr_pstb", 32'(p_stb), 1);
      chk("wr_ack", 32'(c_ack), 32'b001);
      chk("wr_pdat", 32'(p_dat), 32'hA5);
      chk("wr_padr", 32'(p_adr), 3);
      chk("wr_grant", 32'(grant), 32'b001);
      tick();
      c_stb = '0;
      #1 chk("wr_busy_after", 32'(busy), 0);
      tick();

      // c0 and c1 held together: alternate with one bubble between
      do_reset();
      c_stb = 3'b011; c_we = '0; ack_en = 1'b1;
      for (int k = 0; k < 13; k++) begin
         logic [N-1:0] eg;
         eg = (k % 2 == 0) ? 3'b000 : (((k / 2) % 2 == 0) ? 3'b001 : 3'b010);
         #1 chk("rr_grant", 32'(grant), 32'(eg));
         tick();
      end
      c_stb = '0;
      tick();

      // c1 read, peripheral never acks -> watchdog error
      do_reset();
      c_stb = 3'b010; c_we = '0; ack_en = 1'b0;
      for (int k = 0; k < 18; k++) begin
         #1;
         if (k >= 1 && k <= 15) chk("to_noack", 32'(c_ack), 0);
         if (k == 16) begin
            chk("to_ack", 32'(c_ack), 32'b010);
            chk("to_err", 32'(c_err), 32'b010);
            chk("to_rdat", 32'(c_rdat), 0);
            chk("to_pstb", 32'(p_stb), 0);
         end
         if (k == 17) chk("to_idle", 32'(busy), 0);
         tick();
         if (k == 16) c_stb = '0;
      end

      // c0 read returns peripheral data only with ack
      do_reset();
      c_stb = 3'b001; c_we = '0; p_rdat = 8'h3C; ack_en = 1'b1;
      #1 chk("rd_rdat_idle", 32'(c_rdat), 0);
      tick();
      #1;
      chk("rd_rdat", 32'(c_rdat), 32'h3C);
      chk("rd_ack", 32'(c_ack), 32'b001);
      tick();
      c_stb = '0;
      #1 chk("rd_rdat_after", 32'(c_rdat), 0);
      tick();

      // reset in BUSY drops everything at once and restores last
      do_reset();
      c_stb = 3'b001; ack_en = 1'b0;
      tick();
      #1 chk("mr_busy", 32'(busy), 1);
      rst = 1'b0;
      #1;
      chk("mr_pstb", 32'(p_stb), 0);
      chk("mr_grant", 32'(grant), 0);
      chk("mr_busy0", 32'(busy), 0);
      model_reset();
      rst = 1'b1;
      c_stb = 3'b011;
      tick();
      #1 chk("mr_regrant", 32'(grant), 32'b001);
      tick();
      c_stb = '0;
      tick();
      tick();

      // randomized traffic
      do_reset();
      @(negedge clk);
      noack = 0;
      prev_grant = '0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      e_ack = '0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (c_stb[i] && e_ack[i]) begin
               c_stb[i] = 1'b0;
            end else if (c_stb[i]) begin
               if ($urandom_range(0, 49) == 0) c_stb[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               c_stb[i] = 1'b1;
               c_we[i] = 1'($urandom);
               c_adr[i*AW +: AW] = AW'($urandom);
               c_dat[i*DW +: DW] = DW'($urandom);
            end
            if (!c_stb[i]) wait_cnt[i] = 0;
         end
         if ($urandom_range(0, 79) == 0) noack = !noack;
         ack_en = noack ? 1'b0 : ($urandom_range(0, 3) != 0);
         p_rdat = DW'($urandom);
         #1;
         if (grant != '0 && prev_grant == '0) begin
            for (int i = 0; i < N; i++) begin
               if (grant[i]) begin
                  chk("fair", 32'(wait_cnt[i] < N), 1);
                  wait_cnt[i] = 0;
               end else if (c_stb[i]) begin
                  wait_cnt[i]++;
               end
            end
         end
         prev_grant = grant;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
